// File: rtl/inst_fetch_buffer_pkg.sv
// Shared types for the instruction fetch buffer: per-entry fill state and the entry record.
package inst_fetch_buffer_pkg;

    localparam int IFB_EXC_W = 5;

    typedef enum logic {
        IFB_WAIT = 1'b0,
        IFB_DONE = 1'b1
    } ifb_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 live;
        ifb_state_e           state;
        logic [31:0]          pc;
        logic [31:0]          inst;
        logic                 ex;
        logic [IFB_EXC_W-1:0] exccode;
    } ifb_entry_t;

endpackage

// File: rtl/inst_fetch_buffer_if.sv
// Allocation, ICache request/response and dequeue signals of the fetch buffer.
interface inst_fetch_buffer_if #(
    parameter int DEPTH   = 16,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2
);
    import inst_fetch_buffer_pkg::*;

    logic                           flush;
    logic                           alloc_valid;
    logic                           alloc_ready;
    logic [31:0]                    alloc_pc;
    logic [FETCH_W-1:0]             alloc_mask;
    logic                           alloc_ex;
    logic [IFB_EXC_W-1:0]           alloc_exccode;
    logic                           req_valid;
    logic [31:0]                    req_pc;
    logic                           req_ready;
    logic                           resp_valid;
    logic [32*FETCH_W-1:0]          resp_data;
    logic                           resp_ex;
    logic [IFB_EXC_W-1:0]           resp_exccode;
    logic [ISSUE_W-1:0]             deq_valid;
    logic [ISSUE_W-1:0]             deq_live;
    logic [32*ISSUE_W-1:0]          deq_inst;
    logic [32*ISSUE_W-1:0]          deq_pc;
    logic [ISSUE_W-1:0]             deq_ex;
    logic [IFB_EXC_W*ISSUE_W-1:0]   deq_exccode;
    logic [$clog2(ISSUE_W+1)-1:0]   deq_count;
    logic [$clog2(DEPTH+1)-1:0]     count;

    modport slave (
        input  flush, alloc_valid, alloc_pc, alloc_mask, alloc_ex, alloc_exccode,
               req_ready, resp_valid, resp_data, resp_ex, resp_exccode, deq_count,
        output alloc_ready, req_valid, req_pc, deq_valid, deq_live, deq_inst, deq_pc,
               deq_ex, deq_exccode, count
    );

    modport master (
        output flush, alloc_valid, alloc_pc, alloc_mask, alloc_ex, alloc_exccode,
               req_ready, resp_valid, resp_data, resp_ex, resp_exccode, deq_count,
        input  alloc_ready, req_valid, req_pc, deq_valid, deq_live, deq_inst, deq_pc,
               deq_ex, deq_exccode, count
    );

endinterface

// File: rtl/inst_fetch_buffer_deq_select.sv
// Dequeue lane selection: in-order prefix of completed entries starting at head, plus payload mux.
module ifb_deq_select
    import inst_fetch_buffer_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ISSUE_W = 2
) (
    input  ifb_entry_t                   entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]     head,
    output logic [ISSUE_W-1:0]           deq_valid,
    output logic [ISSUE_W-1:0]           deq_live,
    output logic [32*ISSUE_W-1:0]        deq_inst,
    output logic [32*ISSUE_W-1:0]        deq_pc,
    output logic [ISSUE_W-1:0]           deq_ex,
    output logic [IFB_EXC_W*ISSUE_W-1:0] deq_exccode
);
    localparam int PTR_W = $clog2(DEPTH);

    ifb_entry_t e;
    logic       chain;

    // NOTE: every output and temporary gets a default first, so no path leaves a latch behind.
    always_comb begin
        deq_valid   = '0;
        deq_live    = '0;
        deq_inst    = '0;
        deq_pc      = '0;
        deq_ex      = '0;
        deq_exccode = '0;
        e           = '0;
        chain       = 1'b1;
        for (int i = 0; i < ISSUE_W; i++) begin
            e     = entries[head + PTR_W'(i)];
            // A lane is only offered if every older lane is offered too.
            chain = chain && e.valid && (e.state == IFB_DONE);
            deq_valid[i]                        = chain;
            deq_live[i]                         = e.live;
            deq_inst[32*i +: 32]                = e.inst;
            deq_pc[32*i +: 32]                  = e.pc;
            deq_ex[i]                           = e.ex;
            deq_exccode[IFB_EXC_W*i +: IFB_EXC_W] = e.exccode;
        end
    end

endmodule

// File: rtl/inst_fetch_buffer.sv
// Circular instruction fetch buffer with tail/fill/head pointers and a single outstanding ICache request.
// Optional full-cycle performance counter enabled by defining IFB_PERF_CNT_EN.
module inst_fetch_buffer
    import inst_fetch_buffer_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    inst_fetch_buffer_if.slave  bus
`ifdef IFB_PERF_CNT_EN
    ,
    output logic [31:0]         full_cycles
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    ifb_entry_t       entries [DEPTH];
    logic [PTR_W-1:0] tail, fill, head;
    logic [CNT_W-1:0] count_q;
    logic             outstanding, cancel;

    logic fill_pending, fill_exc, req_fire, resp_take, alloc_fire;

    assign fill_pending = entries[fill].valid && (entries[fill].state == IFB_WAIT);
    // A group tagged with a prefetch exception completes without touching the ICache.
    assign fill_exc     = fill_pending && entries[fill].ex;

    assign bus.req_valid   = fill_pending && !entries[fill].ex && !outstanding && !cancel;
    assign bus.req_pc      = entries[fill].pc & ~32'h3;
    assign req_fire        = bus.req_valid && bus.req_ready;
    assign resp_take       = bus.resp_valid && outstanding && !cancel;
    assign bus.alloc_ready = (DEPTH - int'(count_q)) >= FETCH_W;
    assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;
    assign bus.count       = count_q;

    // NOTE: the entry array is reset like any other register because valid/state live inside it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            tail        <= '0;
            fill        <= '0;
            head        <= '0;
            count_q     <= '0;
            outstanding <= 1'b0;
            cancel      <= 1'b0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
            tail        <= '0;
            fill        <= '0;
            head        <= '0;
            count_q     <= '0;
            outstanding <= 1'b0;
            // A response arriving in the flush cycle itself settles the in-flight request.
            cancel      <= ((outstanding || cancel) && !bus.resp_valid) || req_fire;
        end else begin
            for (int i = 0; i < ISSUE_W; i++)
                if (i < int'(bus.deq_count)) entries[head + PTR_W'(i)].valid <= 1'b0;
            head <= head + PTR_W'(bus.deq_count);

            if (fill_exc) begin
                for (int j = 0; j < FETCH_W; j++) begin
                    entries[fill + PTR_W'(j)].state <= IFB_DONE;
                    entries[fill + PTR_W'(j)].inst  <= '0;
                end
                fill <= fill + PTR_W'(FETCH_W);
            end else if (resp_take) begin
                for (int j = 0; j < FETCH_W; j++) begin
                    entries[fill + PTR_W'(j)].state   <= IFB_DONE;
                    entries[fill + PTR_W'(j)].inst    <= bus.resp_data[32*j +: 32];
                    entries[fill + PTR_W'(j)].ex      <= bus.resp_ex;
                    entries[fill + PTR_W'(j)].exccode <= bus.resp_exccode;
                end
                fill        <= fill + PTR_W'(FETCH_W);
                outstanding <= 1'b0;
            end else if (req_fire) begin
                outstanding <= 1'b1;
            end

            if (bus.resp_valid && cancel) cancel <= 1'b0;

            if (alloc_fire) begin
                for (int j = 0; j < FETCH_W; j++)
                    entries[tail + PTR_W'(j)] <= '{valid: 1'b1, live: bus.alloc_mask[j],
                        state: IFB_WAIT, pc: bus.alloc_pc + 32'(4 * j), inst: '0,
                        ex: bus.alloc_ex, exccode: bus.alloc_exccode};
                tail <= tail + PTR_W'(FETCH_W);
            end

            count_q <= count_q + (alloc_fire ? CNT_W'(FETCH_W) : CNT_W'(0)) - CNT_W'(bus.deq_count);
        end
    end

`ifdef IFB_PERF_CNT_EN
    // Saturating; flush leaves it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            full_cycles <= '0;
        else if (count_q == CNT_W'(DEPTH) && full_cycles != '1)
            full_cycles <= full_cycles + 32'd1;
    end
`else
    // Full-cycle counter compiled out.
`endif

    ifb_deq_select #(.DEPTH(DEPTH), .ISSUE_W(ISSUE_W)) u_deq_select (
        .entries     (entries),
        .head        (head),
        .deq_valid   (bus.deq_valid),
        .deq_live    (bus.deq_live),
        .deq_inst    (bus.deq_inst),
        .deq_pc      (bus.deq_pc),
        .deq_ex      (bus.deq_ex),
        .deq_exccode (bus.deq_exccode)
    );

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Scoreboard bench for inst_fetch_buffer: directed allocation groups, an ICache responder and a dequeue monitor.
module tb_inst_fetch_buffer;

    logic clk;
    logic reset;

    inst_fetch_buffer_if #(.DEPTH(16), .FETCH_W(2), .ISSUE_W(2)) bus ();

`ifdef IFB_PERF_CNT_EN
    logic [31:0] full_cycles;
`endif

    inst_fetch_buffer #(.DEPTH(16), .FETCH_W(2), .ISSUE_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef IFB_PERF_CNT_EN
        ,
        .full_cycles (full_cycles)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        live;
        logic        ex;
        logic [4:0]  code;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          deq_budget = 0;
    int          max_count  = 0;
    logic        icache_ex  = 1'b0;
    logic [4:0]  icache_code = 5'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return ((pc - 32'h1000) >> 2) + 32'd1;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ICache: answers each accepted request three cycles later with inst_of(pc) per slot.
    initial begin
        logic [31:0] pc;
        bus.resp_valid   = 1'b0;
        bus.resp_data    = '0;
        bus.resp_ex      = 1'b0;
        bus.resp_exccode = '0;
        forever begin
            @(negedge clk); #2;
            bus.resp_valid = 1'b0;
            if (!reset && bus.req_valid && bus.req_ready) begin
                pc = bus.req_pc;
                repeat (3) @(negedge clk);
                #2;
                bus.resp_valid   = 1'b1;
                bus.resp_data    = {inst_of(pc + 32'd4), inst_of(pc)};
                bus.resp_ex      = icache_ex;
                bus.resp_exccode = icache_code;
            end
        end
    end

    // Monitor: consumes up to deq_budget in-order lanes and compares them against the scoreboard.
    initial begin
        exp_t e;
        int   take;
        bus.deq_count = '0;
        forever begin
            @(negedge clk); #1;
            take = 0;
            if (!reset && !bus.flush)
                for (int i = 0; i < 2; i++)
                    if (bus.deq_valid[i] && take == i && take < deq_budget) take++;
            for (int i = 0; i < take; i++) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL deq_unexpected lane=%0d actual_pc=%0h required=none", i, bus.deq_pc[32*i +: 32]);
                end else begin
                    e = exp_q.pop_front();
                    check("deq_entry",
                          {bus.deq_pc[32*i +: 32], bus.deq_inst[32*i +: 32], bus.deq_live[i],
                           bus.deq_ex[i], bus.deq_exccode[5*i +: 5]},
                          {e.pc, e.inst, e.live, e.ex, e.code});
                end
            end
            bus.deq_count = 2'(take);
            if (int'(bus.count) > max_count) max_count = int'(bus.count);
        end
    end

    task automatic do_alloc(input logic [31:0] pc, input logic [1:0] mask,
                            input logic ex, input logic [4:0] code);
        int   n = 0;
        exp_t e;
        while (!bus.alloc_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.alloc_ready) begin
            check("alloc_ready_timeout", bus.alloc_ready, 1);
            return;
        end
        bus.alloc_valid   = 1'b1;
        bus.alloc_pc      = pc;
        bus.alloc_mask    = mask;
        bus.alloc_ex      = ex;
        bus.alloc_exccode = code;
        for (int j = 0; j < 2; j++) begin
            e.pc   = pc + 32'(4 * j);
            e.live = mask[j];
            e.ex   = ex ? 1'b1 : icache_ex;
            e.code = ex ? code : icache_code;
            e.inst = ex ? 32'h0 : inst_of(e.pc);
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.alloc_valid = 1'b0;
        bus.alloc_ex    = 1'b0;
    endtask

    task automatic wait_deq(input logic [1:0] want, input string name);
        int n = 0;
        while (bus.deq_valid != want && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, bus.deq_valid, want);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        reset             = 1'b1;
        bus.flush         = 1'b0;
        bus.alloc_valid   = 1'b0;
        bus.alloc_pc      = '0;
        bus.alloc_mask    = '0;
        bus.alloc_ex      = 1'b0;
        bus.alloc_exccode = '0;
        bus.req_ready     = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_alloc_ready", bus.alloc_ready, 1);
        check("rst_req_valid", bus.req_valid, 0);
        check("rst_deq_valid", bus.deq_valid, 0);
        check("rst_count", bus.count, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single group: 0x1000 with data {2,1}.
        do_alloc(32'h1000, 2'b11, 1'b0, 5'h0);
        wait_deq(2'b11, "basic_deq_valid");
        check("basic_deq_pc", bus.deq_pc, 64'h00001004_00001000);
        check("basic_deq_inst", bus.deq_inst, 64'h00000002_00000001);
        deq_budget = 2;
        wait_drain("basic_drain");
        check("basic_count", bus.count, 0);

        // Partial dequeue of one lane; lane1 waits for the next group.
        deq_budget = 0;
        do_alloc(32'h2000, 2'b11, 1'b0, 5'h0);
        wait_deq(2'b11, "part_deq_valid");
        deq_budget = 1;
        @(negedge clk);
        deq_budget = 0;
        check("part_one_left", bus.deq_valid, 2'b01);
        check("part_lane0_pc", bus.deq_pc[31:0], 32'h2004);
        do_alloc(32'h3000, 2'b11, 1'b0, 5'h0);
        check("part_lane1_wait", bus.deq_valid, 2'b01);
        wait_deq(2'b11, "part_lane1_done");
        check("part_pcs", bus.deq_pc, 64'h00003000_00002004);
        deq_budget = 2;
        wait_drain("part_drain");

        // Prefetch exception: no ICache request, done the cycle after allocation.
        deq_budget = 0;
        do_alloc(32'h4000, 2'b11, 1'b1, 5'h04);
        check("exc_no_req", bus.req_valid, 0);
        @(negedge clk);
        check("exc_deq_valid", bus.deq_valid, 2'b11);
        check("exc_deq_ex", bus.deq_ex, 2'b11);
        check("exc_deq_inst", bus.deq_inst, 64'h0);
        check("exc_deq_code", bus.deq_exccode, 10'h084);
        deq_budget = 2;
        wait_drain("exc_drain");

        // Fetch-time exception copied to every slot, half-live group.
        icache_ex   = 1'b1;
        icache_code = 5'h0C;
        do_alloc(32'h5000, 2'b01, 1'b0, 5'h0);
        wait_drain("resp_ex_drain");
        icache_ex   = 1'b0;
        icache_code = 5'h0;

        // Fill to capacity with requests held off.
        bus.req_ready = 1'b0;
        deq_budget    = 0;
        for (int g = 0; g < 8; g++) do_alloc(32'h6000 + 32'(8 * g), 2'b11, 1'b0, 5'h0);
        check("full_count", bus.count, 16);
        check("full_alloc_ready", bus.alloc_ready, 0);
        bus.alloc_valid = 1'b1;
        bus.alloc_pc    = 32'hDEAD0000;
        @(negedge clk);
        bus.alloc_valid = 1'b0;
        check("full_alloc_blocked", bus.count, 16);
`ifdef IFB_PERF_CNT_EN
        check("full_cycles_counted", full_cycles != 32'd0, 1);
`endif
        bus.req_ready = 1'b1;
        deq_budget    = 2;
        n = 0;
        while (bus.count == 16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("full_count_after_deq", bus.count, 14);
        check("full_ready_after_deq", bus.alloc_ready, 1);
        wait_drain("full_drain");

        // Flush with a request in flight: its late response must be dropped.
        do_alloc(32'h7000, 2'b11, 1'b0, 5'h0);
        check("flush_req_pending", bus.req_valid, 1);
        @(negedge clk);
        bus.flush = 1'b1;
        exp_q.delete();
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_count", bus.count, 0);
        check("flush_deq_valid", bus.deq_valid, 0);
        do_alloc(32'h8000, 2'b11, 1'b0, 5'h0);
        check("flush_cancel_blocks_req", bus.req_valid, 0);
        check("flush_new_count", bus.count, 2);
        wait_drain("flush_drain");

        // Sustained traffic across many wraps of all three pointers.
        max_count = 0;
        for (int g = 0; g < 40; g++) begin
            deq_budget = (g % 4 == 3) ? 1 : 2;
            do_alloc(32'h10000 + 32'(8 * g), 2'(g % 4), 1'b0, 5'h0);
        end
        deq_budget = 2;
        wait_drain("stress_drain");
        check("stress_peak_count", max_count, 16);
        check("stress_final_count", bus.count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
